ysyx_24100006_axi_arbiter: RTL and testbench

YSYX_24100006_AXI_ARBITER -- requirements
Module: ysyx_24100006_axi_arbiter

---
 rtl/ysyx_24100006_axi_pkg.sv | 21 ++
 rtl/ysyx_24100006_axi_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_ysyx_24100006_axi_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24100006_axi_pkg.sv
// Shared definitions for the IFU/LSU AXI arbiter: FSM encoding, grant
// pointer values and the write-priority rule.
package ysyx_24100006_axi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_IFU_RD = 2'd1,
      ST_LSU_RD = 2'd2,
      ST_LSU_WR = 2'd3
   } arb_state_e;

   // A pending LSU write is served before any read request when set.
   localparam bit WR_PRIORITY = 1'b1;

   localparam logic GNT_IFU = 1'b0;
   localparam logic GNT_LSU = 1'b1;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

endpackage

// File: rtl/ysyx_24100006_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one AXI master arbiter.
// One whole transaction per grant; reads are round-robin, writes go first.
module ysyx_24100006_axi_arbiter
   import ysyx_24100006_axi_pkg::*;
#(
   parameter bit RR_INIT     = 1'b0,
   parameter int RD_ONLY_IFU = 1
) (
   input  logic              clk,
   input  logic              reset,
   // IFU read port
   input  logic              ifu_arvalid,
   output logic              ifu_arready,
   input  logic [ADDR_W-1:0] ifu_araddr,
   input  logic [7:0]        ifu_arlen,
   input  logic [2:0]        ifu_arsize,
   output logic              ifu_rvalid,
   input  logic              ifu_rready,
   output logic [DATA_W-1:0] ifu_rdata,
   output logic [1:0]        ifu_rresp,
   output logic              ifu_rlast,
   // LSU read port
   input  logic              lsu_arvalid,
   output logic              lsu_arready,
   input  logic [ADDR_W-1:0] lsu_araddr,
   input  logic [7:0]        lsu_arlen,
   input  logic [2:0]        lsu_arsize,
   output logic              lsu_rvalid,
   input  logic              lsu_rready,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic [1:0]        lsu_rresp,
   output logic              lsu_rlast,
   // LSU write port
   input  logic              lsu_awvalid,
   output logic              lsu_awready,
   input  logic [ADDR_W-1:0] lsu_awaddr,
   input  logic [7:0]        lsu_awlen,
   input  logic [2:0]        lsu_awsize,
   input  logic              lsu_wvalid,
   output logic              lsu_wready,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [3:0]        lsu_wstrb,
   input  logic              lsu_wlast,
   output logic              lsu_bvalid,
   input  logic              lsu_bready,
   output logic [1:0]        lsu_bresp,
   // Downstream master
   output logic              m_axi_awvalid,
   input  logic              m_axi_awready,
   output logic [ADDR_W-1:0] m_axi_awaddr,
   output logic [7:0]        m_axi_awlen,
   output logic [2:0]        m_axi_awsize,
   output logic              m_axi_wvalid,
   input  logic              m_axi_wready,
   output logic [DATA_W-1:0] m_axi_wdata,
   output logic [3:0]        m_axi_wstrb,
   output logic              m_axi_wlast,
   input  logic              m_axi_bvalid,
   output logic              m_axi_bready,
   input  logic [1:0]        m_axi_bresp,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic [7:0]        m_axi_arlen,
   output logic [2:0]        m_axi_arsize,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready,
   input  logic [DATA_W-1:0] m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rlast,
   output logic [1:0]        m_addr_suffix,
   output logic              busy
);

   // The IFU has no write channels, so only the read-only configuration exists.
   if (RD_ONLY_IFU == 0) begin : g_ifu_wr_unsupported
      $error("ysyx_24100006_axi_arbiter: IFU write path is not implemented");
   end

   arb_state_e state_q, state_d;
   arb_state_e gnt;
   logic       rr_q, rr_d;
   logic [1:0] suffix_q, suffix_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         rr_q     <= RR_INIT;
         suffix_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         suffix_q <= suffix_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      suffix_d = suffix_q;
      if (m_axi_arvalid && m_axi_arready) begin
         suffix_d = m_axi_araddr[1:0];
      end
      case (state_q)
         ST_IDLE: begin
            if (WR_PRIORITY && lsu_awvalid) begin
               state_d = ST_LSU_WR;
            end else if (ifu_arvalid && lsu_arvalid) begin
               // Tie: serve whichever port was not granted last time.
               if (rr_q == GNT_IFU) begin
                  state_d = ST_LSU_RD;
                  rr_d    = GNT_LSU;
               end else begin
                  state_d = ST_IFU_RD;
                  rr_d    = GNT_IFU;
               end
            end else if (ifu_arvalid) begin
               state_d = ST_IFU_RD;
               rr_d    = GNT_IFU;
            end else if (lsu_arvalid) begin
               state_d = ST_LSU_RD;
               rr_d    = GNT_LSU;
            end else if (lsu_awvalid) begin
               state_d = ST_LSU_WR;
            end
         end
         ST_IFU_RD, ST_LSU_RD: begin
            if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
               state_d = ST_IDLE;
            end
         end
         ST_LSU_WR: begin
            if (m_axi_bvalid && m_axi_bready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // While reset is held the routing is cut so no handshake can complete.
   assign gnt           = reset ? state_q : ST_IDLE;
   assign busy          = (state_q != ST_IDLE);
   assign m_addr_suffix = suffix_q;

   always_comb begin
      ifu_arready   = 1'b0;
      ifu_rvalid    = 1'b0;
      ifu_rdata     = '0;
      ifu_rresp     = 2'b00;
      ifu_rlast     = 1'b0;
      lsu_arready   = 1'b0;
      lsu_rvalid    = 1'b0;
      lsu_rdata     = '0;
      lsu_rresp     = 2'b00;
      lsu_rlast     = 1'b0;
      lsu_awready   = 1'b0;
      lsu_wready    = 1'b0;
      lsu_bvalid    = 1'b0;
      lsu_bresp     = 2'b00;
      m_axi_awvalid = 1'b0;
      m_axi_awaddr  = '0;
      m_axi_awlen   = 8'd0;
      m_axi_awsize  = 3'd0;
      m_axi_wvalid  = 1'b0;
      m_axi_wdata   = '0;
      m_axi_wstrb   = 4'd0;
      m_axi_wlast   = 1'b0;
      m_axi_bready  = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_araddr  = '0;
      m_axi_arlen   = 8'd0;
      m_axi_arsize  = 3'd0;
      m_axi_rready  = 1'b0;
      case (gnt)
         ST_IFU_RD: begin
            m_axi_arvalid = ifu_arvalid;
            m_axi_araddr  = ifu_araddr;
            m_axi_arlen   = ifu_arlen;
            m_axi_arsize  = ifu_arsize;
            ifu_arready   = m_axi_arready;
            ifu_rvalid    = m_axi_rvalid;
            ifu_rdata     = m_axi_rdata;
            ifu_rresp     = m_axi_rresp;
            ifu_rlast     = m_axi_rlast;
            m_axi_rready  = ifu_rready;
         end
         ST_LSU_RD: begin
            m_axi_arvalid = lsu_arvalid;
            m_axi_araddr  = lsu_araddr;
            m_axi_arlen   = lsu_arlen;
            m_axi_arsize  = lsu_arsize;
            lsu_arready   = m_axi_arready;
            lsu_rvalid    = m_axi_rvalid;
            lsu_rdata     = m_axi_rdata;
            lsu_rresp     = m_axi_rresp;
            lsu_rlast     = m_axi_rlast;
            m_axi_rready  = lsu_rready;
         end
         ST_LSU_WR: begin
            m_axi_awvalid = lsu_awvalid;
            m_axi_awaddr  = lsu_awaddr;
            m_axi_awlen   = lsu_awlen;
            m_axi_awsize  = lsu_awsize;
            lsu_awready   = m_axi_awready;
            m_axi_wvalid  = lsu_wvalid;
            m_axi_wdata   = lsu_wdata;
            m_axi_wstrb   = lsu_wstrb;
            m_axi_wlast   = lsu_wlast;
            lsu_wready    = m_axi_wready;
            lsu_bvalid    = m_axi_bvalid;
            lsu_bresp     = m_axi_bresp;
            m_axi_bready  = lsu_bready;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ysyx_24100006_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI arbiter; upstream R/B beats are
// checked against a scoreboard filled when the slave side drives them.
module tb_ysyx_24100006_axi_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
   logic [31:0] ifu_araddr, ifu_rdata;
   logic [7:0]  ifu_arlen;
   logic [2:0]  ifu_arsize;
   logic [1:0]  ifu_rresp;
   logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
   logic [31:0] lsu_araddr, lsu_rdata;
   logic [7:0]  lsu_arlen;
   logic [2:0]  lsu_arsize;
   logic [1:0]  lsu_rresp;
   logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_wlast;
   logic        lsu_bvalid, lsu_bready;
   logic [31:0] lsu_awaddr, lsu_wdata;
   logic [7:0]  lsu_awlen;
   logic [2:0]  lsu_awsize;
   logic [3:0]  lsu_wstrb;
   logic [1:0]  lsu_bresp;
   logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
   logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic        m_axi_rvalid, m_axi_rready, m_axi_rlast;
   logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
   logic [7:0]  m_axi_awlen, m_axi_arlen;
   logic [2:0]  m_axi_awsize, m_axi_arsize;
   logic [3:0]  m_axi_wstrb;
   logic [1:0]  m_axi_bresp, m_axi_rresp, m_addr_suffix;
   logic        busy;

   ysyx_24100006_axi_arbiter #(.RR_INIT(1'b0), .RD_ONLY_IFU(1)) dut (
      .clk(clk), .reset(reset),
      .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
      .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_rvalid(ifu_rvalid),
      .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
      .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
      .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_rvalid(lsu_rvalid),
      .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast),
      .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr),
      .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize), .lsu_wvalid(lsu_wvalid),
      .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast),
      .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
      .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wlast(m_axi_wlast), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_bresp(m_axi_bresp), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
      .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
      .m_addr_suffix(m_addr_suffix), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          port;   // 0 IFU R, 1 LSU R, 2 LSU B
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mon(input int port, input logic [31:0] d, input logic [1:0] r, input logic l);
      exp_t e;
      n_cmp++;
      assert (sb.size() > 0) else begin
         n_err++;
         $error("FAIL sb_unexpected: observed beat on port %0d data %h, expected none", port, d);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("sb_port", port, e.port);
         check("sb_data", d, e.data);
         check("sb_resp", {30'd0, r}, {30'd0, e.resp});
         check("sb_last", {31'd0, l}, {31'd0, e.last});
      end
   endtask

   always @(negedge clk) begin
      if (ifu_rvalid) mon(0, ifu_rdata, ifu_rresp, ifu_rlast);
      if (lsu_rvalid) mon(1, lsu_rdata, lsu_rresp, lsu_rlast);
      if (lsu_bvalid) mon(2, 32'h0, lsu_bresp, 1'b1);
   end

   // Slave drives one R beat at posedge+1; it is accepted on the next posedge.
   task automatic slave_r(input int port, input logic [31:0] d, input logic [1:0] r, input logic l);
      exp_t e;
      e.port = port; e.data = d; e.resp = r; e.last = l;
      sb.push_back(e);
      m_axi_rvalid = 1'b1; m_axi_rdata = d; m_axi_rresp = r; m_axi_rlast = l;
      tick();
      m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
   endtask

   task automatic wait_ar(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (!m_axi_arvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      assert (m_axi_arvalid === 1'b1) else begin
         n_err++;
         $error("FAIL %s: m_axi_arvalid observed %b expected 1 within 20 cycles", tag, m_axi_arvalid);
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: observed no finish, expected finish before 50000 ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      ifu_arvalid = 0; ifu_araddr = '0; ifu_arlen = 0; ifu_arsize = 0; ifu_rready = 1;
      lsu_arvalid = 0; lsu_araddr = '0; lsu_arlen = 0; lsu_arsize = 0; lsu_rready = 1;
      lsu_awvalid = 0; lsu_awaddr = '0; lsu_awlen = 0; lsu_awsize = 0;
      lsu_wvalid = 0; lsu_wdata = '0; lsu_wstrb = 0; lsu_wlast = 0; lsu_bready = 1;
      m_axi_awready = 1; m_axi_wready = 1; m_axi_arready = 1;
      m_axi_bvalid = 0; m_axi_bresp = 0;
      m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 0; m_axi_rlast = 0;

      // Reset with a request pending: nothing may be granted or forwarded.
      tick();
      ifu_arvalid = 1; ifu_araddr = 32'h8000_0000;
      tick();
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_m_arvalid", m_axi_arvalid, 0);
      check("rst_ifu_arready", ifu_arready, 0);
      check("rst_suffix", m_addr_suffix, 0);
      check("rst_m_rready", m_axi_rready, 0);
      tick();
      ifu_arvalid = 0; reset = 1'b1;
      tick();

      // Single-beat IFU read of 0x8000_0000.
      ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; ifu_arlen = 0; ifu_arsize = 3'd2;
      @(negedge clk);
      check("s1_arb_lat_busy", busy, 0);
      check("s1_arb_lat_arvalid", m_axi_arvalid, 0);
      wait_ar("s1_ar");
      check("s1_araddr", m_axi_araddr, 32'h8000_0000);
      check("s1_ifu_arready", ifu_arready, 1);
      check("s1_lsu_arready", lsu_arready, 0);
      tick();
      ifu_arvalid = 0;
      slave_r(0, 32'hDEAD_BEEF, 2'b00, 1'b1);
      @(negedge clk);
      check("s1_idle_after_r", busy, 0);
      check("s1_suffix", m_addr_suffix, 0);
      tick();

      // Simultaneous requests: LSU first (RR_INIT=0), then IFU.
      ifu_arvalid = 1; ifu_araddr = 32'h8000_0001; ifu_arsize = 3'd0;
      lsu_arvalid = 1; lsu_araddr = 32'h1000_0002; lsu_arlen = 0; lsu_arsize = 3'd1;
      wait_ar("s2_ar1");
      check("s2_first_addr", m_axi_araddr, 32'h1000_0002);
      check("s2_first_lsu_rdy", lsu_arready, 1);
      check("s2_first_ifu_rdy", ifu_arready, 0);
      tick();
      lsu_arvalid = 0;
      @(negedge clk);
      check("s2_suffix_lsu", m_addr_suffix, 2);
      check("s2_ifu_waits", ifu_arready, 0);
      tick();
      slave_r(1, 32'hA5A5_0001, 2'b00, 1'b1);
      lsu_arvalid = 1; lsu_araddr = 32'h1000_0003;
      wait_ar("s2_ar2");
      check("s2_second_addr", m_axi_araddr, 32'h8000_0001);
      check("s2_second_ifu_rdy", ifu_arready, 1);
      check("s2_second_lsu_rdy", lsu_arready, 0);
      tick();
      ifu_arvalid = 0;
      slave_r(0, 32'hA5A5_0002, 2'b00, 1'b1);
      wait_ar("s2_ar3");
      check("s2_third_addr", m_axi_araddr, 32'h1000_0003);
      check("s2_suffix_holds", m_addr_suffix, 1);
      tick();
      lsu_arvalid = 0;
      slave_r(1, 32'hA5A5_0003, 2'b00, 1'b1);
      @(negedge clk);
      check("s2_suffix_last", m_addr_suffix, 3);
      check("s2_idle", busy, 0);
      tick();

      // Write beats a pending IFU read; the IFU read is a 4-beat burst.
      lsu_awvalid = 1; lsu_awaddr = 32'h0000_1000; lsu_awlen = 0; lsu_awsize = 3'd2;
      lsu_wvalid = 1; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'hF; lsu_wlast = 1;
      ifu_arvalid = 1; ifu_araddr = 32'h8000_0010; ifu_arlen = 8'd3; ifu_arsize = 3'd2;
      @(negedge clk);
      check("s3_arb_lat", busy, 0);
      @(negedge clk);
      check("s3_m_awvalid", m_axi_awvalid, 1);
      check("s3_m_awaddr", m_axi_awaddr, 32'h0000_1000);
      check("s3_m_wdata", m_axi_wdata, 32'h1234_5678);
      check("s3_m_wstrb", m_axi_wstrb, 4'hF);
      check("s3_m_arvalid", m_axi_arvalid, 0);
      check("s3_ifu_arready", ifu_arready, 0);
      check("s3_lsu_awready", lsu_awready, 1);
      check("s3_lsu_wready", lsu_wready, 1);
      tick();
      lsu_awvalid = 0; lsu_wvalid = 0;
      sb.push_back('{2, 32'h0, 2'b00, 1'b1});
      m_axi_bvalid = 1; m_axi_bresp = 2'b00;
      @(negedge clk);
      check("s3_ifu_blocked_b", m_axi_arvalid, 0);
      check("s3_busy_b", busy, 1);
      tick();
      m_axi_bvalid = 0;
      @(negedge clk);
      check("s3_idle_after_b", busy, 0);
      check("s3_no_ar_idle", m_axi_arvalid, 0);
      wait_ar("s3_ifu_ar");
      check("s3_ifu_addr", m_axi_araddr, 32'h8000_0010);
      check("s3_ifu_arlen", m_axi_arlen, 8'd3);
      tick();
      ifu_arvalid = 0;
      slave_r(0, 32'hB000_0000, 2'b00, 1'b0);
      lsu_arvalid = 1; lsu_araddr = 32'h0200_0000; lsu_arlen = 0; lsu_arsize = 3'd2;
      for (int b = 1; b < 4; b++) begin
         @(negedge clk);
         check("s4_lsu_blocked", lsu_arready, 0);
         check("s4_m_arvalid", m_axi_arvalid, 0);
         check("s4_busy", busy, 1);
         tick();
         slave_r(0, 32'hB000_0000 + b, 2'b00, b == 3);
      end
      @(negedge clk);
      check("s4_idle", busy, 0);
      check("s4_lsu_still_wait", lsu_arready, 0);

      // LSU read of 0x0200_0000 with SLVERR.
      wait_ar("s5_ar");
      check("s5_addr", m_axi_araddr, 32'h0200_0000);
      check("s5_lsu_rdy", lsu_arready, 1);
      tick();
      lsu_arvalid = 0;
      slave_r(1, 32'hC0DE_0000, 2'b10, 1'b1);
      @(negedge clk);
      check("s5_idle", busy, 0);
      tick();

      // Reset in LSU_RD after the first beat of a 2-beat burst.
      lsu_arvalid = 1; lsu_araddr = 32'h0300_0001; lsu_arlen = 8'd1;
      wait_ar("s6_ar");
      check("s6_addr", m_axi_araddr, 32'h0300_0001);
      tick();
      lsu_arvalid = 0;
      slave_r(1, 32'hD000_0001, 2'b00, 1'b0);
      m_axi_rvalid = 1; m_axi_rdata = 32'hD000_0002; m_axi_rlast = 1;
      reset = 1'b0;
      tick();
      @(negedge clk);
      check("s6_busy", busy, 0);
      check("s6_m_arvalid", m_axi_arvalid, 0);
      check("s6_m_awvalid", m_axi_awvalid, 0);
      check("s6_m_wvalid", m_axi_wvalid, 0);
      check("s6_m_rready", m_axi_rready, 0);
      check("s6_m_bready", m_axi_bready, 0);
      check("s6_lsu_rvalid", lsu_rvalid, 0);
      check("s6_ifu_rvalid", ifu_rvalid, 0);
      check("s6_suffix", m_addr_suffix, 0);
      tick();
      m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rlast = 0;
      reset = 1'b1;
      tick();

      // Pointer is back at RR_INIT: a tie goes to the LSU again.
      ifu_arvalid = 1; ifu_araddr = 32'h8000_0020; ifu_arlen = 0;
      lsu_arvalid = 1; lsu_araddr = 32'h0400_0000; lsu_arlen = 0;
      wait_ar("s7_ar");
      check("s7_lsu_wins", lsu_arready, 1);
      check("s7_addr", m_axi_araddr, 32'h0400_0000);
      tick();
      lsu_arvalid = 0;
      slave_r(1, 32'hE000_0001, 2'b00, 1'b1);
      wait_ar("s7_ar2");
      check("s7_ifu_next", ifu_arready, 1);
      tick();
      ifu_arvalid = 0;
      slave_r(0, 32'hE000_0002, 2'b00, 1'b1);
      @(negedge clk);
      check("s7_idle", busy, 0);
      check("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
